// File: rtl/regfile_sb_bypass_pkg.sv
// Shared register-file constants for the decode, hazard and register-file blocks.
// Defaults for data and address width, plus the hard-wired zero register address.
package regfile_sb_bypass_pkg;
   localparam int unsigned XLEN_DEF   = 32;
   localparam int unsigned ADDR_W_DEF = 5;
   localparam int unsigned NUM_RD_DEF = 2;
   localparam int unsigned ZERO_ADDR  = 0;
endpackage

// File: rtl/regfile_sb_bypass_if.sv
// Decode-stage register-file bus: read ports, writeback, issue reservation and flush.
// The master drives addresses and controls; the slave (the register file) returns data and busy.
interface regfile_sb_bypass_if
   import regfile_sb_bypass_pkg::*;
#(
   parameter int XLEN   = XLEN_DEF,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int NUM_RD = NUM_RD_DEF
) ();
   logic [NUM_RD*ADDR_W-1:0] rd_addr;
   logic [NUM_RD*XLEN-1:0]   rd_data;
   logic [NUM_RD-1:0]        rd_busy;
   logic                     hazard;
   logic [NUM_RD-1:0]        rd_use;
   logic                     wr_en;
   logic [ADDR_W-1:0]        wr_addr;
   logic [XLEN-1:0]          wr_data;
   logic                     wr_release;
   logic                     iss_en;
   logic [ADDR_W-1:0]        iss_addr;
   logic                     flush;

   modport master (
      output rd_addr, rd_use, wr_en, wr_addr, wr_data, wr_release, iss_en, iss_addr, flush,
      input  rd_data, rd_busy, hazard
   );

   modport slave (
      input  rd_addr, rd_use, wr_en, wr_addr, wr_data, wr_release, iss_en, iss_addr, flush,
      output rd_data, rd_busy, hazard
   );
endinterface

// File: rtl/regfile_rd_port.sv
// One read port: zero-register, write-bypass and busy resolution on top of the stored state.
// Purely combinational, zero latency; a forwarded writeback also hides that register's busy bit.
module regfile_rd_port
   import regfile_sb_bypass_pkg::*;
#(
   parameter int XLEN     = XLEN_DEF,
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic [ADDR_W-1:0] rd_addr_i,
   input  logic [XLEN-1:0]   stored_data_i,
   input  logic              stored_busy_i,
   input  logic              wr_en_i,
   input  logic [ADDR_W-1:0] wr_addr_i,
   input  logic [XLEN-1:0]   wr_data_i,
   input  logic              wr_release_i,
   output logic [XLEN-1:0]   rd_data_o,
   output logic              rd_busy_o
);
   localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(ZERO_ADDR);

   logic is_zero;
   logic fwd_hit;

   assign is_zero = (ZERO_REG != 0) && (rd_addr_i == ZERO_A);
   assign fwd_hit = (BYPASS != 0) && wr_en_i && (wr_addr_i == rd_addr_i);

   always_comb begin
      rd_data_o = stored_data_i;
      rd_busy_o = stored_busy_i;
      if (is_zero) begin
         rd_data_o = '0;
         rd_busy_o = 1'b0;
      end else if (fwd_hit) begin
         rd_data_o = wr_data_i;
         // The releasing value is forwarded right now, so the consumer need not stall.
         if (wr_release_i) rd_busy_o = 1'b0;
      end
   end
endmodule

// File: rtl/regfile_sb_bypass.sv
// Parametrised multi-read, single-write register file with busy scoreboard and write bypass.
// Reads and hazard are combinational (zero latency); writes, reservations and flush land on the clock edge.
module regfile_sb_bypass
   import regfile_sb_bypass_pkg::*;
#(
   parameter int XLEN     = XLEN_DEF,
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int NUM_RD   = NUM_RD_DEF,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input logic                clk,
   input logic                rst,
   regfile_sb_bypass_if.slave rf_bus
);
   localparam int NREGS = 2**ADDR_W;
   localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(ZERO_ADDR);

   logic [XLEN-1:0]        mem_q [NREGS];
   logic [NREGS-1:0]       busy_q;
   logic [NREGS-1:0]       busy_d;
   logic                   wr_ok;
   logic [NUM_RD*XLEN-1:0] rd_data_w;
   logic [NUM_RD-1:0]      rd_busy_w;

   assign wr_ok = rf_bus.wr_en && !((ZERO_REG != 0) && (rf_bus.wr_addr == ZERO_A));

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < NREGS; i++) mem_q[i] <= '0;
      end else if (wr_ok) begin
         mem_q[rf_bus.wr_addr] <= rf_bus.wr_data;
      end
   end

   // Flush drops same-cycle releases; a reservation always lands last so the issuer survives.
   always_comb begin
      busy_d = busy_q;
      if (rf_bus.flush) busy_d = '0;
      else if (rf_bus.wr_en && rf_bus.wr_release) busy_d[rf_bus.wr_addr] = 1'b0;
      if (rf_bus.iss_en) busy_d[rf_bus.iss_addr] = 1'b1;
      if (ZERO_REG != 0) busy_d[ZERO_A] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!rst) busy_q <= '0;
      else      busy_q <= busy_d;
   end

   for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      logic [ADDR_W-1:0] addr;
      assign addr = rf_bus.rd_addr[k*ADDR_W +: ADDR_W];

      regfile_rd_port #(
         .XLEN     (XLEN),
         .ADDR_W   (ADDR_W),
         .ZERO_REG (ZERO_REG),
         .BYPASS   (BYPASS)
      ) u_port (
         .rd_addr_i     (addr),
         .stored_data_i (mem_q[addr]),
         .stored_busy_i (busy_q[addr]),
         .wr_en_i       (rf_bus.wr_en),
         .wr_addr_i     (rf_bus.wr_addr),
         .wr_data_i     (rf_bus.wr_data),
         .wr_release_i  (rf_bus.wr_release),
         .rd_data_o     (rd_data_w[k*XLEN +: XLEN]),
         .rd_busy_o     (rd_busy_w[k])
      );
   end

   assign rf_bus.rd_data = rd_data_w;
   assign rf_bus.rd_busy = rd_busy_w;
   assign rf_bus.hazard  = |(rd_busy_w & rf_bus.rd_use);
endmodule

// File: tb/tb_regfile_sb_bypass.sv
// Bench for the scoreboarded register file: bypass and non-bypass 2-port copies follow a
// reference model every cycle; a 4-port 64-bit copy is checked with directed reads.
module tb_regfile_sb_bypass;
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   regfile_sb_bypass_if #(.XLEN(32), .ADDR_W(5), .NUM_RD(2)) ifa ();
   regfile_sb_bypass_if #(.XLEN(32), .ADDR_W(5), .NUM_RD(2)) ifb ();
   regfile_sb_bypass_if #(.XLEN(64), .ADDR_W(5), .NUM_RD(4)) ifc ();

   regfile_sb_bypass #(.XLEN(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1), .BYPASS(1))
      dut_a (.clk(clk), .rst(rst), .rf_bus(ifa));
   regfile_sb_bypass #(.XLEN(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1), .BYPASS(0))
      dut_b (.clk(clk), .rst(rst), .rf_bus(ifb));
   regfile_sb_bypass #(.XLEN(64), .ADDR_W(5), .NUM_RD(4), .ZERO_REG(1), .BYPASS(1))
      dut_c (.clk(clk), .rst(rst), .rf_bus(ifc));

   // Shared stimulus for the two 2-port copies
   logic [9:0]  rd_addr;
   logic [1:0]  rd_use;
   logic        wr_en, wr_release, iss_en, flush;
   logic [4:0]  wr_addr, iss_addr;
   logic [31:0] wr_data;

   assign ifa.rd_addr = rd_addr;     assign ifb.rd_addr = rd_addr;
   assign ifa.rd_use = rd_use;       assign ifb.rd_use = rd_use;
   assign ifa.wr_en = wr_en;         assign ifb.wr_en = wr_en;
   assign ifa.wr_addr = wr_addr;     assign ifb.wr_addr = wr_addr;
   assign ifa.wr_data = wr_data;     assign ifb.wr_data = wr_data;
   assign ifa.wr_release = wr_release; assign ifb.wr_release = wr_release;
   assign ifa.iss_en = iss_en;       assign ifb.iss_en = iss_en;
   assign ifa.iss_addr = iss_addr;   assign ifb.iss_addr = iss_addr;
   assign ifa.flush = flush;         assign ifb.flush = flush;

   // Reference model: architectural registers plus a set of reserved register numbers
   bit [31:0] m_mem [32];
   bit        m_busy [32];
   bit        model_live = 1'b0;

   always @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < 32; i++) begin
            m_mem[i]  = '0;
            m_busy[i] = 1'b0;
         end
         model_live = 1'b1;
      end else begin
         if (wr_en && wr_addr != 0) m_mem[wr_addr] = wr_data;
         if (flush) begin
            for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
         end else if (wr_en && wr_release) begin
            m_busy[wr_addr] = 1'b0;
         end
         if (iss_en && iss_addr != 0) m_busy[iss_addr] = 1'b1;
      end
   end

   function automatic logic [31:0] exp_data(int k, bit byp);
      logic [4:0] a;
      a = rd_addr[k*5 +: 5];
      if (a == 0) return 32'h0;
      if (byp && wr_en && wr_addr == a) return wr_data;
      return m_mem[a];
   endfunction

   function automatic logic exp_busy(int k, bit byp);
      logic [4:0] a;
      a = rd_addr[k*5 +: 5];
      if (a == 0) return 1'b0;
      if (byp && wr_en && wr_release && wr_addr == a) return 1'b0;
      return m_busy[a];
   endfunction

   function automatic logic exp_hazard(bit byp);
      logic h;
      h = 1'b0;
      for (int k = 0; k < 2; k++) h = h | (rd_use[k] & exp_busy(k, byp));
      return h;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (model_live) begin
         for (int k = 0; k < 2; k++) begin
            check($sformatf("a_data%0d", k), 64'(ifa.rd_data[k*32 +: 32]), 64'(exp_data(k, 1'b1)));
            check($sformatf("a_busy%0d", k), 64'(ifa.rd_busy[k]), 64'(exp_busy(k, 1'b1)));
            check($sformatf("b_data%0d", k), 64'(ifb.rd_data[k*32 +: 32]), 64'(exp_data(k, 1'b0)));
            check($sformatf("b_busy%0d", k), 64'(ifb.rd_busy[k]), 64'(exp_busy(k, 1'b0)));
         end
         check("a_hazard", 64'(ifa.hazard), 64'(exp_hazard(1'b1)));
         check("b_hazard", 64'(ifb.hazard), 64'(exp_hazard(1'b0)));
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      wr_en = 0; wr_release = 0; iss_en = 0; flush = 0;
      wr_addr = '0; wr_data = '0; iss_addr = '0; rd_use = '0;
   endtask

   task automatic settle();
      #1;
   endtask

   logic [63:0] pat [4];

   initial begin
      pat[0] = 64'h0123_4567_89AB_CDEF;
      pat[1] = 64'hFEDC_BA98_7654_3210;
      pat[2] = 64'hA5A5_5A5A_0F0F_F0F0;
      pat[3] = 64'h8000_0000_0000_0001;
      idle();
      rd_addr = '0;
      ifc.rd_addr = '0; ifc.rd_use = '0; ifc.wr_en = 0; ifc.wr_addr = '0; ifc.wr_data = '0;
      ifc.wr_release = 0; ifc.iss_en = 0; ifc.iss_addr = '0; ifc.flush = 0;
      rst = 0;
      step(); step();
      rst = 1;
      settle();
      check("rst_busy_a", 64'(ifa.rd_busy), 64'h0);
      check("rst_hazard_a", 64'(ifa.hazard), 64'h0);

      // Reset overrides a write in the same cycle
      wr_en = 1; wr_addr = 5; wr_data = 32'hDEADBEEF;
      step();
      idle(); rd_addr = {5'd6, 5'd5};
      settle();
      check("pre_rst_r5", 64'(ifa.rd_data[31:0]), 64'hDEADBEEF);
      rst = 0; wr_en = 1; wr_addr = 6; wr_data = 32'h1111_2222;
      step();
      rst = 1; idle();
      settle();
      check("rst_r5", 64'(ifa.rd_data[31:0]), 64'h0);
      check("rst_r6", 64'(ifa.rd_data[63:32]), 64'h0);
      check("rst_busy", 64'(ifa.rd_busy), 64'h0);

      // Same-cycle bypass vs. stored value next cycle
      wr_en = 1; wr_addr = 7; wr_data = 32'h12345678; rd_addr = {5'd0, 5'd7};
      settle();
      check("byp_a", 64'(ifa.rd_data[31:0]), 64'h12345678);
      check("nobyp_b_old", 64'(ifb.rd_data[31:0]), 64'h0);
      step();
      idle();
      settle();
      check("nobyp_b_new", 64'(ifb.rd_data[31:0]), 64'h12345678);

      // Zero register ignores writes and reservations
      wr_en = 1; wr_addr = 0; wr_data = 32'hFFFFFFFF; iss_en = 1; iss_addr = 0; rd_addr = '0;
      settle();
      check("zero_data", 64'(ifa.rd_data), 64'h0);
      step();
      idle();
      settle();
      check("zero_data_after", 64'(ifa.rd_data), 64'h0);
      check("zero_busy_after", 64'(ifa.rd_busy), 64'h0);

      // Reserve, stall, then release with forwarding
      iss_en = 1; iss_addr = 3;
      step();
      idle(); rd_addr = {5'd0, 5'd3}; rd_use = 2'b01;
      settle();
      check("sb_hazard_a", 64'(ifa.hazard), 64'h1);
      rd_use = 2'b10;
      settle();
      check("sb_unused_port", 64'(ifa.hazard), 64'h0);
      rd_use = 2'b01; wr_en = 1; wr_addr = 3; wr_data = 32'hA5A5A5A5; wr_release = 1;
      settle();
      check("rel_hazard_a", 64'(ifa.hazard), 64'h0);
      check("rel_fwd_a", 64'(ifa.rd_data[31:0]), 64'hA5A5A5A5);
      check("rel_hazard_b", 64'(ifb.hazard), 64'h1);
      step();
      idle(); rd_use = 2'b01;
      settle();
      check("post_rel_hazard_b", 64'(ifb.hazard), 64'h0);

      // Issue and release of the same register: set wins
      iss_en = 1; iss_addr = 9; wr_en = 1; wr_addr = 9; wr_data = 32'h99; wr_release = 1;
      step();
      idle(); rd_addr = {5'd4, 5'd9};
      settle();
      check("set_wins", 64'(ifa.rd_busy), 64'b01);
      // Flush with a same-cycle issue keeps only the issuer
      flush = 1; iss_en = 1; iss_addr = 4;
      step();
      idle();
      settle();
      check("flush_iss", 64'(ifa.rd_busy), 64'b10);
      iss_en = 1; iss_addr = 4;
      step();
      idle();
      settle();
      check("waw_busy", 64'(ifa.rd_busy), 64'b10);

      // Randomised traffic over a small register window, checked by the model each cycle
      for (int n = 0; n < 300; n++) begin
         rd_addr    = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
         rd_use     = 2'($urandom_range(0, 3));
         wr_en      = 1'($urandom_range(0, 1));
         wr_addr    = 5'($urandom_range(0, 7));
         wr_data    = $urandom;
         wr_release = 1'($urandom_range(0, 1));
         iss_en     = 1'($urandom_range(0, 1));
         iss_addr   = 5'($urandom_range(0, 7));
         flush      = ($urandom_range(0, 15) == 0);
         step();
      end
      idle();

      // Wide four-port copy: each port returns its own register
      for (int i = 0; i < 4; i++) begin
         ifc.wr_en = 1; ifc.wr_addr = 5'(i + 1); ifc.wr_data = pat[i];
         step();
      end
      ifc.wr_en = 0;
      ifc.rd_addr = {5'd4, 5'd3, 5'd2, 5'd1};
      settle();
      for (int k = 0; k < 4; k++)
         check($sformatf("wide_p%0d", k), ifc.rd_data[k*64 +: 64], pat[k]);
      ifc.rd_addr = {5'd1, 5'd2, 5'd3, 5'd4};
      settle();
      for (int k = 0; k < 4; k++)
         check($sformatf("wide_rev_p%0d", k), ifc.rd_data[k*64 +: 64], pat[3-k]);
      check("wide_busy", 64'(ifc.rd_busy), 64'h0);

      step();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/regfile_sb_bypass.md
Name: regfile_sb_bypass

Overview:
- Parametrised successor to the core's 2R1W integer register file.
- Configurable data width, register count and number of read ports.
- Adds optional write-to-read bypass and a per-register busy scoreboard (reserve at issue, release at writeback, bulk flush) with a hazard output for the pipeline stall logic.
- Sits in the decode stage: reads operands, and reserves destinations for the instructions it issues.

Parameters:
XLEN, 32, data width of each register
ADDR_W, 5, register address width; NREGS = 2**ADDR_W
NUM_RD, 2, number of independent read ports (1..4)
ZERO_REG, 1, 1: register 0 reads as 0, ignores writes and is never busy
BYPASS, 1, 1: a same-cycle write is forwarded to matching read ports

Ports:
clk  in  1  clock, all state updates on the rising edge
rst  in  1  synchronous, active-low reset
rd_addr  in  NUM_RD*ADDR_W  read addresses, port k at bits [k*ADDR_W +: ADDR_W]
rd_data  out  NUM_RD*XLEN  read data, port k at bits [k*XLEN +: XLEN]
rd_busy  out  NUM_RD  port k's address is reserved (pending write)
hazard  out  1  OR of the rd_busy bits for ports enabled in rd_use
rd_use  in  NUM_RD  port k's operand is actually consumed this cycle
wr_en  in  1  writeback enable
wr_addr  in  ADDR_W  writeback address
wr_data  in  XLEN  writeback data
wr_release  in  1  writeback also clears the busy bit of wr_addr
iss_en  in  1  reserve a destination register
iss_addr  in  ADDR_W  destination to reserve
flush  in  1  clear all busy bits (pipeline flush)

Behaviour:
- Storage: NREGS x XLEN data array plus an NREGS-bit busy vector.
- Reset: while rst=0 at a rising edge, all registers and busy bits clear to 0. Reset overrides write, issue and flush. After reset: rd_data=0 on all ports, rd_busy=0, hazard=0.
- Write: at the edge with wr_en=1, reg[wr_addr] <= wr_data. Ignored when ZERO_REG=1 and wr_addr=0.
- Read: combinational, zero latency. Port k resolves in priority order:
  - ZERO_REG=1 and address 0 -> 0.
  - BYPASS=1, wr_en=1 and wr_addr==rd_addr_k (and not the zero register) -> wr_data.
  - Otherwise -> reg[rd_addr_k].
  - With BYPASS=0 the stored value is returned; the new value appears the next cycle.
- Scoreboard, evaluated per edge in this order:
  1. flush=1 clears all busy bits and discards any release in the same cycle.
  2. iss_en=1 sets busy[iss_addr], even when flush=1 in the same cycle (the issuing instruction survives the flush).
  3. wr_en & wr_release clears busy[wr_addr], unless wr_addr==iss_addr with iss_en=1 (set wins).
  4. Register 0 is never set when ZERO_REG=1.
- rd_busy[k]:
  - Equals busy[rd_addr_k] in the current state.
  - Forced to 0 when the same-cycle release targets that address and BYPASS=1; the data is being forwarded, so there is no stall.
  - Forced to 0 for the zero register.
- hazard = |(rd_busy & rd_use). Purely combinational, no registered delay.
- Issue to an already-busy register keeps it busy (WAW). The block does not count outstanding writers; the pipeline guarantees in-order writeback.
- Width rules: no arithmetic. Addresses are always in range because NREGS = 2**ADDR_W.

Decomposition:
- Shared package/header: ADDR_W, XLEN defaults and the ZERO_REG address constant, shared with decode and hazard units.
- One natural sub-module: regfile_rd_port, the per-port zero/bypass/busy mux, instantiated NUM_RD times by generate.

Test Plan:
1. Reset: write reg5=0xDEADBEEF, then hold rst=0 for one edge with wr_en=1 to reg6 -> reg5 and reg6 both read 0; all rd_busy=0.
2. Bypass: wr_en=1, wr_addr=7, wr_data=0x12345678, rd_addr0=7 in the same cycle -> rd_data0=0x12345678 that cycle. With BYPASS=0 the old value is returned, then 0x12345678 the next cycle.
3. Zero register: write 0xFFFFFFFF to addr 0 and issue addr 0 -> rd_data=0, rd_busy=0.
4. Scoreboard: iss_en to addr 3, then read 3 with rd_use=1 -> hazard=1. Writeback to 3 with release -> hazard=0 the same cycle (BYPASS=1), and data is forwarded.
5. Simultaneous events: iss_en to 9 plus release of 9 in the same cycle -> busy[9]=1. Flush plus iss_en to 4 -> only busy[4]=1 remains.
6. NUM_RD=4, XLEN=64: four distinct reads of registers holding 64-bit patterns -> each port returns its own value with no cross-port interference.
